// File: rtl/hazard_ctrl_if.sv
// Hazard unit bus: pipeline register fields in, stall/flush/forward controls out.
// Latency: pure wiring, no state.
// Backpressure: none; stalls are the backpressure the core sees.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  // decode/execute/memory/writeback register indices
  logic [4:0]       RS1D;
  logic [4:0]       RS2D;
  logic [4:0]       RS1E;
  logic [4:0]       RS2E;
  logic [4:0]       RdE;
  logic [4:0]       RdM;
  logic [4:0]       RdW;
  // pipeline qualifiers
  logic             LoadE;
  logic             RegWriteM;
  logic             RegWriteW;
  logic             PCSrcE;
  logic             MemReqM;
  logic             MemAckM;
  logic             CntClr;
  // controls back to the pipeline
  logic             StallF;
  logic             StallD;
  logic             StallE;
  logic             StallM;
  logic             FlushD;
  logic             FlushE;
  logic [1:0]       ForwardAE;
  logic [1:0]       ForwardBE;
  logic             MemErr;
  logic [CNT_W-1:0] StallCnt;

  // pipeline side drives indices and qualifiers, samples controls
  modport master (
    output RS1D, RS2D, RS1E, RS2E, RdE, RdM, RdW,
    output LoadE, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemAckM, CntClr,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE,
    input  ForwardAE, ForwardBE, MemErr, StallCnt
  );

  // hazard unit side
  modport slave (
    input  RS1D, RS2D, RS1E, RS2E, RdE, RdM, RdW,
    input  LoadE, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemAckM, CntClr,
    output StallF, StallD, StallE, StallM, FlushD, FlushE,
    output ForwardAE, ForwardBE, MemErr, StallCnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard/flow control for the 5-stage core: stalls, flushes, forwarding, memory-wait FSM.
// Latency: controls combinational from state+inputs; MemErr and StallCnt registered (1 cycle).
// Backpressure: a memory wait freezes F/D/E/M; branch/load-use actions resume after release.
module hazard_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic         CLK,
  input  logic         RST,
  hazard_ctrl_if.slave bus
);

  typedef enum logic {
    IDLE     = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  // the wait counter is sized for the widest legal TIMEOUT
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  state_t           state;
  logic [15:0]      wait_cnt;
  logic             run;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;

  logic             timeout;
  logic             memwait;
  logic             lw;
  logic             stall_f;
  logic             stall_d;
  logic             stall_e;
  logic             stall_m;
  logic             flush_d;
  logic             flush_e;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;

  // M-stage result wins over W-stage; x0 is hardwired zero so never forwarded
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic       reg_write_m,
    input logic [4:0] rd_m,
    input logic       reg_write_w,
    input logic [4:0] rd_w
  );
    if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs))
      return 2'b10;
    else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  // timeout fires on the last permitted wait cycle; memwait is the live stall request
  always_comb begin
    timeout = (state == MEM_WAIT) && !bus.MemAckM && (wait_cnt == WAIT_LAST);
    memwait = run && (((state == IDLE) && bus.MemReqM && !bus.MemAckM) ||
                      ((state == MEM_WAIT) && !bus.MemAckM && !timeout));
    lw      = bus.LoadE && (bus.RdE != 5'd0) &&
              ((bus.RdE == bus.RS1D) || (bus.RdE == bus.RS2D));
  end

  // stall/flush priority: memory wait, then taken branch, then load-use
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    fwd_a   = 2'b00;
    fwd_b   = 2'b00;
    if (run) begin
      fwd_a = fwd_sel(bus.RS1E, bus.RegWriteM, bus.RdM, bus.RegWriteW, bus.RdW);
      fwd_b = fwd_sel(bus.RS2E, bus.RegWriteM, bus.RdM, bus.RegWriteW, bus.RdW);
      if (memwait) begin
        // freeze everything; a pending branch or load-use is simply re-seen after release
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
      end else if (bus.PCSrcE) begin
        // decode instruction is discarded, so a load-use against it is moot
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (lw) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end
  end

  // run qualifier: keeps controls quiet until the first edge after reset release
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      run <= 1'b0;
    else
      run <= 1'b1;
  end

  // memory-wait FSM with timeout; MemErr is a registered one-cycle pulse
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      wait_cnt <= 16'd0;
      mem_err  <= 1'b0;
    end else begin
      mem_err <= 1'b0;
      if (run) begin
        case (state)
          IDLE: begin
            if (bus.MemReqM && !bus.MemAckM) begin
              state    <= MEM_WAIT;
              wait_cnt <= 16'd1;
            end
          end
          MEM_WAIT: begin
            if (bus.MemAckM) begin
              state    <= IDLE;
              wait_cnt <= 16'd0;
            end else if (timeout) begin
              state    <= IDLE;
              wait_cnt <= 16'd0;
              mem_err  <= 1'b1;
            end else begin
              wait_cnt <= wait_cnt + 16'd1;
            end
          end
        endcase
      end
    end
  end

  // saturating count of fetch-stall cycles; clear beats increment
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      stall_cnt <= '0;
    else if (bus.CntClr)
      stall_cnt <= '0;
    else if (stall_f && (stall_cnt != {CNT_W{1'b1}}))
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

  assign bus.StallF    = stall_f;
  assign bus.StallD    = stall_d;
  assign bus.StallE    = stall_e;
  assign bus.StallM    = stall_m;
  assign bus.FlushD    = flush_d;
  assign bus.FlushE    = flush_e;
  assign bus.ForwardAE = fwd_a;
  assign bus.ForwardBE = fwd_b;
  assign bus.MemErr    = mem_err;
  assign bus.StallCnt  = stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: vector table for forwarding/hazard priority plus
// hand-written sequences for reset, memory wait, timeout and counter saturation.
// Inputs change 1ns after the rising edge; outputs are sampled 2ns after it.
module tb_hazard_ctrl;

  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 16;

  logic CLK;
  logic RST;

  hazard_ctrl_if #(.CNT_W(CNT_W)) hif ();

  hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (hif.slave)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_tests = 0;
  int n_fail  = 0;
  logic [CNT_W-1:0] exp_cnt = '0;

  typedef struct {
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       loade, rwm, rww, pcsrc;
    logic [5:0] ctl;   // {StallF,StallD,StallE,StallM,FlushD,FlushE}
    logic [1:0] fa, fb;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(
    input logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw,
    input logic loade, rwm, rww, pcsrc,
    input logic [5:0] ctl, input logic [1:0] fa, fb);
    vec_t v;
    v.rs1d = rs1d; v.rs2d = rs2d; v.rs1e = rs1e; v.rs2e = rs2e;
    v.rde = rde; v.rdm = rdm; v.rdw = rdw;
    v.loade = loade; v.rwm = rwm; v.rww = rww; v.pcsrc = pcsrc;
    v.ctl = ctl; v.fa = fa; v.fb = fb;
    return v;
  endfunction

  function automatic logic [5:0] ctl_now();
    return {hif.StallF, hif.StallD, hif.StallE, hif.StallM, hif.FlushD, hif.FlushE};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    hif.RS1D = 0; hif.RS2D = 0; hif.RS1E = 0; hif.RS2E = 0;
    hif.RdE = 0; hif.RdM = 0; hif.RdW = 0;
    hif.LoadE = 0; hif.RegWriteM = 0; hif.RegWriteW = 0; hif.PCSrcE = 0;
    hif.MemReqM = 0; hif.MemAckM = 0; hif.CntClr = 0;
  endtask

  // advance one clock; the counter model follows the expected StallF
  task automatic cyc(input logic exp_sf);
    @(posedge CLK);
    if (hif.CntClr) exp_cnt = '0;
    else if (exp_sf && exp_cnt != {CNT_W{1'b1}}) exp_cnt = exp_cnt + 1'b1;
    #1;
  endtask

  task automatic clr_cnt();
    idle_inputs();
    hif.CntClr = 1'b1;
    cyc(1'b0);
    hif.CntClr = 1'b0;
  endtask

  // watchdog: the bench has no open-ended waits, but never hang regardless
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 6'b000000, 2'b00, 2'b00);
    vecs[1]  = mk(0, 0, 5, 0, 0, 5, 5,  0, 1, 1, 0, 6'b000000, 2'b10, 2'b00);
    vecs[2]  = mk(0, 0, 5, 0, 0, 5, 5,  0, 0, 1, 0, 6'b000000, 2'b01, 2'b00);
    vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0,  0, 1, 1, 0, 6'b000000, 2'b00, 2'b00);
    vecs[4]  = mk(0, 0, 3, 9, 0, 3, 9,  0, 1, 1, 0, 6'b000000, 2'b10, 2'b01);
    vecs[5]  = mk(0, 0, 4, 4, 0, 4, 4,  0, 0, 1, 0, 6'b000000, 2'b01, 2'b01);
    vecs[6]  = mk(0, 7, 0, 0, 7, 0, 0,  1, 0, 0, 0, 6'b110001, 2'b00, 2'b00);
    vecs[7]  = mk(0, 7, 0, 0, 7, 0, 0,  1, 0, 0, 1, 6'b000011, 2'b00, 2'b00);
    vecs[8]  = mk(0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 6'b000000, 2'b00, 2'b00);
    vecs[9]  = mk(7, 0, 0, 0, 7, 0, 0,  0, 0, 0, 0, 6'b000000, 2'b00, 2'b00);
    vecs[10] = mk(12, 3, 0, 0, 12, 0, 0, 1, 0, 0, 0, 6'b110001, 2'b00, 2'b00);
    vecs[11] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 6'b000011, 2'b00, 2'b00);
    vecs[12] = mk(8, 0, 6, 6, 8, 6, 6,  1, 1, 1, 0, 6'b110001, 2'b10, 2'b10);

    // ---- reset and run qualifier
    idle_inputs();
    RST = 1'b0;
    hif.PCSrcE = 1'b1;
    repeat (2) @(posedge CLK);
    #2;
    chk("reset_ctl", 32'(ctl_now()), 32'h0);
    chk("reset_cnt", 32'(hif.StallCnt), 32'h0);
    chk("reset_err", 32'(hif.MemErr), 32'h0);
    RST = 1'b1;
    #1;
    chk("prerun_ctl", 32'(ctl_now()), 32'h0);
    cyc(1'b0);
    #1;
    chk("run_branch_ctl", 32'(ctl_now()), 32'(6'b000011));

    // ---- table: forwarding, load-use, branch priority
    clr_cnt();
    for (int i = 0; i < 13; i++) begin
      hif.RS1D = vecs[i].rs1d; hif.RS2D = vecs[i].rs2d;
      hif.RS1E = vecs[i].rs1e; hif.RS2E = vecs[i].rs2e;
      hif.RdE = vecs[i].rde; hif.RdM = vecs[i].rdm; hif.RdW = vecs[i].rdw;
      hif.LoadE = vecs[i].loade; hif.RegWriteM = vecs[i].rwm;
      hif.RegWriteW = vecs[i].rww; hif.PCSrcE = vecs[i].pcsrc;
      #1;
      chk($sformatf("vec%0d_ctl", i), 32'(ctl_now()), 32'(vecs[i].ctl));
      chk($sformatf("vec%0d_fa", i), 32'(hif.ForwardAE), 32'(vecs[i].fa));
      chk($sformatf("vec%0d_fb", i), 32'(hif.ForwardBE), 32'(vecs[i].fb));
      chk($sformatf("vec%0d_cnt", i), 32'(hif.StallCnt), 32'(exp_cnt));
      cyc(vecs[i].ctl[5]);
    end
    idle_inputs();
    #1;
    chk("table_cnt_final", 32'(hif.StallCnt), 32'd3);

    // ---- memory wait: 3 cycles without ack, branch arrives mid-wait
    clr_cnt();
    hif.MemReqM = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      if (i >= 2) hif.PCSrcE = 1'b1;
      #1;
      chk($sformatf("memwait_c%0d_ctl", i), 32'(ctl_now()), 32'(6'b111100));
      cyc(1'b1);
    end
    hif.MemAckM = 1'b1;
    #1;
    chk("memwait_ack_ctl", 32'(ctl_now()), 32'(6'b000011));
    cyc(1'b0);
    idle_inputs();
    #1;
    chk("memwait_after_ctl", 32'(ctl_now()), 32'h0);
    chk("memwait_cnt", 32'(hif.StallCnt), 32'd3);
    hif.MemReqM = 1'b1;
    hif.MemAckM = 1'b1;
    #1;
    chk("mem_immediate_ack_ctl", 32'(ctl_now()), 32'h0);
    cyc(1'b0);
    idle_inputs();
    #1;
    chk("mem_immediate_ack_idle", 32'(ctl_now()), 32'h0);

    // ---- timeout: ack never comes
    clr_cnt();
    hif.MemReqM = 1'b1;
    for (int i = 1; i <= TIMEOUT - 1; i++) begin
      #1;
      chk($sformatf("timeout_c%0d_ctl", i), 32'(ctl_now()), 32'(6'b111100));
      if (i == 1 || i == TIMEOUT - 1)
        chk($sformatf("timeout_c%0d_err", i), 32'(hif.MemErr), 32'h0);
      cyc(1'b1);
    end
    #1;
    chk("timeout_release_ctl", 32'(ctl_now()), 32'h0);
    chk("timeout_release_err", 32'(hif.MemErr), 32'h0);
    cyc(1'b0);
    hif.MemReqM = 1'b0;
    #1;
    chk("timeout_err_pulse", 32'(hif.MemErr), 32'h1);
    chk("timeout_idle_ctl", 32'(ctl_now()), 32'h0);
    cyc(1'b0);
    #1;
    chk("timeout_err_clear", 32'(hif.MemErr), 32'h0);
    chk("timeout_cnt", 32'(hif.StallCnt), 32'd15);

    // ---- saturation and clear-beats-increment
    clr_cnt();
    hif.LoadE = 1'b1; hif.RdE = 5'd7; hif.RS2D = 5'd7;
    for (int i = 0; i < 20; i++) cyc(1'b1);
    #1;
    chk("sat_cnt", 32'(hif.StallCnt), 32'd15);
    chk("sat_model", 32'(hif.StallCnt), 32'(exp_cnt));
    hif.CntClr = 1'b1;
    #1;
    chk("clr_with_stall_ctl", 32'(ctl_now()), 32'(6'b110001));
    cyc(1'b1);
    hif.CntClr = 1'b0;
    #1;
    chk("clr_with_stall_cnt", 32'(hif.StallCnt), 32'd0);
    idle_inputs();
    cyc(1'b0);

    // ---- reset in the middle of a memory wait
    hif.MemReqM = 1'b1;
    repeat (5) cyc(1'b1);
    #2;
    RST = 1'b0;
    exp_cnt = '0;
    #1;
    chk("rst_midwait_ctl", 32'(ctl_now()), 32'h0);
    chk("rst_midwait_cnt", 32'(hif.StallCnt), 32'h0);
    chk("rst_midwait_err", 32'(hif.MemErr), 32'h0);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    #1;
    chk("rst_release_ctl", 32'(ctl_now()), 32'h0);
    cyc(1'b0);
    hif.MemReqM = 1'b0;
    #1;
    chk("rst_state_idle_ctl", 32'(ctl_now()), 32'h0);
    chk("rst_release_cnt", 32'(hif.StallCnt), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
